text_console_writer: RTL and testbench

Writer side of the text-mode character video memory. The VGA character renderer reads this memory: 12-bit cell address = (row<<7) + col, 8-bit ASCII per cell.
- Accepts a stream of ASCII bytes through a valid/ready handshake, for example from the keyboard path.
- Writes printable characters at a hardware cursor.
- Interprets CR, LF and BS.
- Scrolls the screen up one row when the cursor passes the last row.

---
 rtl/text_console_writer.sv | 189 ++++++++++++++++++
 tb/tb_text_console_writer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// Character-cell writer for the text-mode video RAM: cursor, CR/LF/BS and scroll-up.
// Optional CLEAR_SCREEN_EN: byte 0x0C blanks every visible cell and homes the cursor.
module text_console_writer #(
    parameter int COLS = 70,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    output logic        vram_we,
    output logic [11:0] vram_waddr,
    output logic [7:0]  vram_wdata,
    output logic [11:0] vram_raddr,
    input  logic [7:0]  vram_rdata,
    output logic [4:0]  cursor_row,
    output logic [6:0]  cursor_col
);
    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
    localparam logic [4:0] ROW_PEN  = 5'(ROWS - 2);
    localparam logic [7:0] SPACE    = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        PUT,
        SCR_RD,
        SCR_WR,
        CLR
`ifdef CLEAR_SCREEN_EN
        , FF_CLR
`endif
    } state_t;

    state_t     state, state_n;
    logic [4:0] row, row_n, r, r_n;
    logic [6:0] col, col_n, c, c_n;
    logic [7:0] data, data_n;
    logic       advance, advance_n;
    logic       accept;

    assign cursor_row = row;
    assign cursor_col = col;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            row     <= '0;
            col     <= '0;
            data    <= '0;
            advance <= 1'b0;
            r       <= '0;
            c       <= '0;
        end else begin
            state   <= state_n;
            row     <= row_n;
            col     <= col_n;
            data    <= data_n;
            advance <= advance_n;
            r       <= r_n;
            c       <= c_n;
        end
    end

    always_comb begin
        state_n    = state;
        row_n      = row;
        col_n      = col;
        data_n     = data;
        advance_n  = advance;
        r_n        = r;
        c_n        = c;
        vram_we    = 1'b0;
        vram_waddr = '0;
        vram_wdata = '0;
        vram_raddr = '0;
        char_ready = (state == IDLE) && !reset;
        accept     = char_valid && char_ready;

        case (state)
            IDLE: begin
                r_n = '0;
                c_n = '0;
                if (accept) begin
                    if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                        data_n    = char_data;
                        advance_n = 1'b1;
                        state_n   = PUT;
                    end else if (char_data == 8'h0D) begin
                        col_n = '0;
                    end else if (char_data == 8'h0A) begin
                        col_n = '0;
                        if (row == ROW_LAST) state_n = SCR_RD;
                        else                 row_n   = row + 5'd1;
                    end else if (char_data == 8'h08) begin
                        // Backspace moves first, then PUT blanks the new cell without advancing.
                        if (col != '0) begin
                            col_n     = col - 7'd1;
                            data_n    = SPACE;
                            advance_n = 1'b0;
                            state_n   = PUT;
                        end else if (row != '0) begin
                            row_n     = row - 5'd1;
                            col_n     = COL_LAST;
                            data_n    = SPACE;
                            advance_n = 1'b0;
                            state_n   = PUT;
                        end
                    end
`ifdef CLEAR_SCREEN_EN
                    else if (char_data == 8'h0C) begin
                        state_n = FF_CLR;
                    end
`endif
                end
            end
            PUT: begin
                vram_we    = 1'b1;
                vram_waddr = {row, col};
                vram_wdata = data;
                r_n        = '0;
                c_n        = '0;
                state_n    = IDLE;
                if (advance) begin
                    if (col == COL_LAST) begin
                        col_n = '0;
                        if (row == ROW_LAST) state_n = SCR_RD;
                        else                 row_n   = row + 5'd1;
                    end else begin
                        col_n = col + 7'd1;
                    end
                end
            end
            SCR_RD: begin
                vram_raddr = {r + 5'd1, c};
                state_n    = SCR_WR;
            end
            SCR_WR: begin
                // RAM read is registered, so the cell fetched in SCR_RD arrives now.
                vram_we    = 1'b1;
                vram_waddr = {r, c};
                vram_wdata = vram_rdata;
                state_n    = SCR_RD;
                if (c == COL_LAST) begin
                    c_n = '0;
                    if (r == ROW_PEN) state_n = CLR;
                    else              r_n     = r + 5'd1;
                end else begin
                    c_n = c + 7'd1;
                end
            end
            CLR: begin
                vram_we    = 1'b1;
                vram_waddr = {ROW_LAST, c};
                vram_wdata = SPACE;
                if (c == COL_LAST) begin
                    c_n     = '0;
                    row_n   = ROW_LAST;
                    col_n   = '0;
                    state_n = IDLE;
                end else begin
                    c_n = c + 7'd1;
                end
            end
`ifdef CLEAR_SCREEN_EN
            FF_CLR: begin
                vram_we    = 1'b1;
                vram_waddr = {r, c};
                vram_wdata = SPACE;
                if (c == COL_LAST) begin
                    c_n = '0;
                    if (r == ROW_LAST) begin
                        r_n     = '0;
                        row_n   = '0;
                        col_n   = '0;
                        state_n = IDLE;
                    end else begin
                        r_n = r + 5'd1;
                    end
                end else begin
                    c_n = c + 7'd1;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: vector table plus scroll/reset/clear sequences,
// with a registered-read RAM model and a write scoreboard.
module tb_text_console_writer;
    localparam int COLS = 70;
    localparam int ROWS = 30;
    localparam int unsigned LIMIT = 10000;

    logic        clk = 1'b0;
    logic        reset;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        vram_we;
    logic [11:0] vram_waddr;
    logic [7:0]  vram_wdata;
    logic [11:0] vram_raddr;
    logic [7:0]  vram_rdata;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;

    text_console_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk        (clk),
        .reset      (reset),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .vram_we    (vram_we),
        .vram_waddr (vram_waddr),
        .vram_wdata (vram_wdata),
        .vram_raddr (vram_raddr),
        .vram_rdata (vram_rdata),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [7:0]  data;
        logic        wr;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic [4:0]  row;
        logic [6:0]  col;
        int unsigned busy;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];
    logic preload = 1'b0;
    logic [7:0] mem [4096];

    function automatic logic [7:0] pat(input logic [11:0] a);
        return {3'b000, a[11:7]} * 8'd8 + {5'b00000, a[2:0]} + 8'd1;
    endfunction

    // RAM model with one-cycle registered read
    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < 4096; a++) mem[a] <= pat(12'(a));
        end else if (vram_we) begin
            mem[vram_waddr] <= vram_wdata;
        end
        vram_rdata <= mem[vram_raddr];
    end

    always @(negedge clk) begin
        if (vram_we) begin
            wr_t w;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h required=none", vram_waddr, vram_wdata);
            end else begin
                w = exp_q.pop_front();
                if (w.addr !== vram_waddr || w.data !== vram_wdata) begin
                    errors++;
                    $display("FAIL write addr=%h data=%h required addr=%h data=%h",
                             vram_waddr, vram_wdata, w.addr, w.data);
                end
            end
            checks++;
            if (vram_waddr[6:0] >= 7'(COLS)) begin
                errors++;
                $display("FAIL write_col col=%0d required<%0d", vram_waddr[6:0], COLS);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [11:0] a, input logic [7:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic push_scroll(input logic ovr, input logic [6:0] ovr_col, input logic [7:0] ovr_data);
        for (int r = 0; r < ROWS - 1; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (ovr && r == ROWS - 2 && c == int'(ovr_col))
                    push({5'(r), 7'(c)}, ovr_data);
                else
                    push({5'(r), 7'(c)}, pat({5'(r + 1), 7'(c)}));
            end
        end
        for (int c = 0; c < COLS; c++) push({5'(ROWS - 1), 7'(c)}, 8'h20);
    endtask

    task automatic do_preload();
        @(negedge clk);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int unsigned n = 0;
        @(negedge clk);
        char_valid = 1'b1;
        char_data  = b;
        while (!char_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(char_ready), 32'd1);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic wait_idle(output int unsigned n);
        n = 0;
        @(negedge clk);
        while (!char_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic send_idle(input logic [7:0] b);
        int unsigned n;
        send(b);
        wait_idle(n);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog time=%0t required_finish_before=%0t", $time, 64'd3_000_000);
        $fatal(1);
    end

    initial begin
        vec_t        vecs[13];
        int unsigned n;

        vecs[0]  = '{8'h41, 1'b1, 12'h000, 8'h41, 5'd0, 7'd1,  1};
        vecs[1]  = '{8'h0D, 1'b0, 12'h000, 8'h00, 5'd0, 7'd0,  0};
        vecs[2]  = '{8'h07, 1'b0, 12'h000, 8'h00, 5'd0, 7'd0,  0};
        vecs[3]  = '{8'h08, 1'b0, 12'h000, 8'h00, 5'd0, 7'd0,  0};
        vecs[4]  = '{8'h0A, 1'b0, 12'h000, 8'h00, 5'd1, 7'd0,  0};
        vecs[5]  = '{8'h42, 1'b1, 12'h080, 8'h42, 5'd1, 7'd1,  1};
        vecs[6]  = '{8'h08, 1'b1, 12'h080, 8'h20, 5'd1, 7'd0,  1};
        vecs[7]  = '{8'h08, 1'b1, 12'h045, 8'h20, 5'd0, 7'd69, 1};
        vecs[8]  = '{8'h7E, 1'b1, 12'h045, 8'h7E, 5'd1, 7'd0,  1};
        vecs[9]  = '{8'h1F, 1'b0, 12'h000, 8'h00, 5'd1, 7'd0,  0};
        vecs[10] = '{8'h7F, 1'b0, 12'h000, 8'h00, 5'd1, 7'd0,  0};
        vecs[11] = '{8'h80, 1'b0, 12'h000, 8'h00, 5'd1, 7'd0,  0};
        vecs[12] = '{8'h20, 1'b1, 12'h080, 8'h20, 5'd1, 7'd1,  1};

        char_valid = 1'b0;
        char_data  = 8'h00;
        reset      = 1'b1;
        do_preload();
        repeat (2) @(negedge clk);
        chk("reset_ready",  32'(char_ready), 32'd0);
        chk("reset_we",     32'(vram_we), 32'd0);
        chk("reset_waddr",  32'(vram_waddr), 32'd0);
        chk("reset_wdata",  32'(vram_wdata), 32'd0);
        chk("reset_raddr",  32'(vram_raddr), 32'd0);
        chk("reset_cursor", 32'({cursor_row, cursor_col}), 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 32'(char_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) push(vecs[i].addr, vecs[i].wdata);
            send(vecs[i].data);
            wait_idle(n);
            chk($sformatf("vec%0d_busy", i), n, vecs[i].busy);
            chk($sformatf("vec%0d_cursor", i), 32'({cursor_row, cursor_col}),
                32'({vecs[i].row, vecs[i].col}));
            chk($sformatf("vec%0d_drain", i), exp_q.size(), 32'd0);
        end

        // First write lands in the cycle right after acceptance
        reset_dut();
        push(12'h000, 8'h41);
        send(8'h41);
        chk("put_we",   32'(vram_we), 32'd1);
        chk("put_addr", 32'(vram_waddr), 32'h000);
        chk("put_data", 32'(vram_wdata), 32'h41);
        wait_idle(n);
        chk("put_busy", n, 32'd1);
        chk("put_cursor", 32'({cursor_row, cursor_col}), 32'({5'd0, 7'd1}));

        // Full row, wrap to next row, then backspace across the row boundary
        reset_dut();
        for (int i = 0; i < COLS; i++) begin
            push(12'(i), 8'(8'h21 + i));
            send_idle(8'(8'h21 + i));
        end
        chk("row_wrap_cursor", 32'({cursor_row, cursor_col}), 32'({5'd1, 7'd0}));
        chk("row_wrap_drain", exp_q.size(), 32'd0);
        push(12'h045, 8'h20);
        send_idle(8'h08);
        chk("bs_wrap_cursor", 32'({cursor_row, cursor_col}), 32'({5'd0, 7'd69}));

        // CR from mid-row and an ignored control byte
        reset_dut();
        repeat (5) send_idle(8'h0A);
        for (int i = 0; i < 10; i++) begin
            push({5'd5, 7'(i)}, 8'h61);
            send_idle(8'h61);
        end
        send(8'h0D);
        wait_idle(n);
        chk("cr_busy", n, 32'd0);
        chk("cr_cursor", 32'({cursor_row, cursor_col}), 32'({5'd5, 7'd0}));
        send_idle(8'h07);
        chk("bel_cursor", 32'({cursor_row, cursor_col}), 32'({5'd5, 7'd0}));

        // LF on the last row scrolls
        reset_dut();
        repeat (ROWS - 1) send_idle(8'h0A);
        chk("last_row_cursor", 32'({cursor_row, cursor_col}), 32'({5'd29, 7'd0}));
        for (int i = 0; i < 5; i++) begin
            push({5'd29, 7'(i)}, 8'h62);
            send_idle(8'h62);
        end
        do_preload();
        push_scroll(1'b0, 7'd0, 8'h00);
        send(8'h0A);
        wait_idle(n);
        chk("lf_scroll_busy", n, 32'd4130);
        chk("lf_scroll_cursor", 32'({cursor_row, cursor_col}), 32'({5'd29, 7'd0}));
        chk("lf_scroll_drain", exp_q.size(), 32'd0);

        // Printable at the bottom-right corner writes, then scrolls
        for (int i = 0; i < COLS - 1; i++) begin
            push({5'd29, 7'(i)}, 8'h63);
            send_idle(8'h63);
        end
        chk("corner_cursor", 32'({cursor_row, cursor_col}), 32'({5'd29, 7'd69}));
        do_preload();
        push({5'd29, 7'd69}, 8'h5A);
        push_scroll(1'b1, 7'd69, 8'h5A);
        send(8'h5A);
        wait_idle(n);
        chk("wrap_scroll_busy", n, 32'd4131);
        chk("wrap_scroll_cursor", 32'({cursor_row, cursor_col}), 32'({5'd29, 7'd0}));
        chk("wrap_scroll_drain", exp_q.size(), 32'd0);

`ifdef CLEAR_SCREEN_EN
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) push({5'(r), 7'(c)}, 8'h20);
        send(8'h0C);
        wait_idle(n);
        chk("ff_busy", n, 32'd2100);
        chk("ff_cursor", 32'({cursor_row, cursor_col}), 32'd0);
        chk("ff_drain", exp_q.size(), 32'd0);
`else
        send(8'h0C);
        wait_idle(n);
        chk("ff_busy", n, 32'd0);
        chk("ff_cursor", 32'({cursor_row, cursor_col}), 32'({5'd29, 7'd0}));
`endif

        // Reset at scroll cycle 100 with a byte pending on the input
        reset_dut();
        repeat (ROWS - 1) send_idle(8'h0A);
        do_preload();
        push_scroll(1'b0, 7'd0, 8'h00);
        send(8'h0A);
        repeat (50) @(negedge clk);
        char_valid = 1'b1;
        char_data  = 8'h43;
        repeat (50) @(negedge clk);
        chk("busy_holds_ready", 32'(char_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("abort_we", 32'(vram_we), 32'd0);
        chk("abort_cursor", 32'({cursor_row, cursor_col}), 32'd0);
        chk("abort_ready", 32'(char_ready), 32'd0);
        repeat (3) @(negedge clk);
        char_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_ready_after", 32'(char_ready), 32'd1);
        repeat (5) @(negedge clk);
        chk("abort_cursor_after", 32'({cursor_row, cursor_col}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
